// File: rtl/feedback_pulse_monitor_if.sv
// Record stream from the pulse monitor to the readout side.
// master drives record_data/record_valid, slave drives record_ready.
interface feedback_pulse_monitor_if #(
  parameter int counterBitSize = 32
);
  logic [2*counterBitSize-1:0] record_data;
  logic                        record_valid;
  logic                        record_ready;

  modport master (
    output record_data,
    output record_valid,
    input  record_ready
  );

  modport slave (
    input  record_data,
    input  record_valid,
    output record_ready
  );
endinterface

// File: rtl/feedback_pulse_monitor.sv
// Measures width and start-to-start interval of every active pulse on the
// feedback value and queues {interval, width} records in a show-ahead FIFO.
// Ports: clk, reset (sync, high), enable, feedbackValue, activeValue,
//   rec (record_data/valid/ready), pulseCount, overflowCount, fifoLevel.
module feedback_pulse_monitor #(
  parameter int valueBitSize   = 16,
  parameter int counterBitSize = 32,
  parameter int fifoDepth      = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic [valueBitSize-1:0]          feedbackValue,
  input  logic [valueBitSize-1:0]          activeValue,
  feedback_pulse_monitor_if.master         rec,
  output logic [counterBitSize-1:0]        pulseCount,
  output logic [15:0]                      overflowCount,
  output logic [$clog2(fifoDepth+1)-1:0]   fifoLevel
);
  localparam int CW = counterBitSize;
  localparam int RW = 2 * counterBitSize;
  localparam int AW = $clog2(fifoDepth);
  localparam int LW = $clog2(fifoDepth + 1);

  typedef enum logic [1:0] {
    s_noRef = 2'd0,
    s_high  = 2'd1,
    s_low   = 2'd2
  } state_t;

  function automatic logic [CW-1:0] satInc(input logic [CW-1:0] x);
    return (&x) ? x : x + CW'(1);
  endfunction

  state_t          state_q, state_d;
  logic            act_q, actPrev_q, en_q;
  logic [CW-1:0]   width_q, width_d;
  logic [CW-1:0]   interval_q, interval_d;
  logic [CW-1:0]   saved_q, saved_d;
  logic            first_q, first_d;
  logic [CW-1:0]   pulse_q, pulse_d;
  logic [15:0]     ovf_q, ovf_d;
  logic [AW-1:0]   wrPtr_q, rdPtr_q;
  logic [LW-1:0]   level_q;
  logic [RW-1:0]   mem [fifoDepth];

  logic          rise, fall;
  logic          push, pop, full, wr;
  logic [RW-1:0] pushData;

  assign rise = act_q & ~actPrev_q;
  assign fall = ~act_q & actPrev_q;

  // en_q is aligned with act_q so a fall caused by enable is recognised
  // in the same cycle the fall itself is seen.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= s_noRef;
      act_q      <= 1'b0;
      actPrev_q  <= 1'b0;
      en_q       <= 1'b0;
      width_q    <= '0;
      interval_q <= '0;
      saved_q    <= '0;
      first_q    <= 1'b0;
      pulse_q    <= '0;
      ovf_q      <= '0;
    end else begin
      state_q    <= state_d;
      act_q      <= enable && (feedbackValue == activeValue);
      actPrev_q  <= act_q;
      en_q       <= enable;
      width_q    <= width_d;
      interval_q <= interval_d;
      saved_q    <= saved_d;
      first_q    <= first_d;
      pulse_q    <= pulse_d;
      ovf_q      <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      s_noRef: if (rise) state_d = s_high;
      s_high:  if (fall) state_d = en_q ? s_low : s_noRef;
      s_low: begin
        if (!en_q)     state_d = s_noRef;
        else if (rise) state_d = s_high;
      end
      default: state_d = s_noRef;
    endcase
  end

  always_comb begin
    width_d    = width_q;
    interval_d = interval_q;
    saved_d    = saved_q;
    first_d    = first_q;
    pulse_d    = pulse_q;
    push       = 1'b0;
    pushData   = {(first_q ? '0 : saved_q), width_q};
    unique case (state_q)
      s_noRef: begin
        if (rise) begin
          width_d    = CW'(1);
          interval_d = CW'(1);
          first_d    = 1'b1;
        end
      end
      s_high: begin
        interval_d = satInc(interval_q);
        if (act_q) width_d = satInc(width_q);
        if (fall) begin
          push    = 1'b1;
          pulse_d = satInc(pulse_q);
        end
      end
      s_low: begin
        interval_d = satInc(interval_q);
        if (rise) begin
          saved_d    = interval_q;
          interval_d = CW'(1);
          width_d    = CW'(1);
          first_d    = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // A pop in the same cycle frees the slot, so a push at full is kept.
  assign full = (level_q == LW'(fifoDepth));
  assign pop  = rec.record_valid && rec.record_ready;
  assign wr   = push && (!full || pop);

  always_comb begin
    ovf_d = ovf_q;
    if (push && full && !pop && !(&ovf_q)) ovf_d = ovf_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
    end else begin
      if (wr)  wrPtr_q <= wrPtr_q + AW'(1);
      if (pop) rdPtr_q <= rdPtr_q + AW'(1);
      if (wr && !pop)      level_q <= level_q + LW'(1);
      else if (!wr && pop) level_q <= level_q - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wrPtr_q] <= pushData;
  end

  assign rec.record_valid = (level_q != '0);
  assign rec.record_data  = rec.record_valid ? mem[rdPtr_q] : '0;
  assign pulseCount       = pulse_q;
  assign overflowCount    = ovf_q;
  assign fifoLevel        = level_q;
endmodule

// File: tb/tb_feedback_pulse_monitor.sv
// Scoreboard bench for feedback_pulse_monitor: directed pulse trains,
// expected records queued at issue time and checked by record monitors.
module tb_feedback_pulse_monitor;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] fb, fbB, act;
  logic [31:0] pcA;
  logic [15:0] ovA, ovB;
  logic [4:0]  lvA, lvB;
  logic [3:0]  pcB;

  int checks = 0;
  int errors = 0;
  logic [63:0] qa[$];
  logic [7:0]  qb[$];
  logic [63:0] expA;
  logic [7:0]  expB;

  always #5 clk = ~clk;

  feedback_pulse_monitor_if #(.counterBitSize(32)) ifA ();
  feedback_pulse_monitor_if #(.counterBitSize(4))  ifB ();

  feedback_pulse_monitor dutA (
    .clk(clk), .reset(reset), .enable(enable),
    .feedbackValue(fb), .activeValue(act), .rec(ifA),
    .pulseCount(pcA), .overflowCount(ovA), .fifoLevel(lvA)
  );

  feedback_pulse_monitor #(.counterBitSize(4)) dutB (
    .clk(clk), .reset(reset), .enable(enable),
    .feedbackValue(fbB), .activeValue(act), .rec(ifB),
    .pulseCount(pcB), .overflowCount(ovB), .fifoLevel(lvB)
  );

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && ifA.record_valid && ifA.record_ready) begin
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL recA_unexpected: got %h expected none",
                 ifA.record_data);
      end else begin
        expA = qa.pop_front();
        chk("recA", ifA.record_data, expA);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && ifB.record_valid && ifB.record_ready) begin
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL recB_unexpected: got %h expected none",
                 ifB.record_data);
      end else begin
        expB = qb.pop_front();
        chk("recB", {56'd0, ifB.record_data}, {56'd0, expB});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulseA(input int n, input int gap);
    fb = act;
    tick(n);
    fb = ~act;
    tick(gap);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    qa.delete();
    tick(2);
  endtask

  initial begin
    act = 16'h1234;
    fb = 16'h0000;
    fbB = 16'h0000;
    ifA.record_ready = 1'b1;
    ifB.record_ready = 1'b1;
    tick(2);
    chk("rst_valid", {63'd0, ifA.record_valid}, 64'd0);
    chk("rst_data", ifA.record_data, 64'd0);
    chk("rst_pulses", {32'd0, pcA}, 64'd0);
    chk("rst_ovf", {48'd0, ovA}, 64'd0);
    chk("rst_level", {59'd0, lvA}, 64'd0);
    reset = 1'b0;
    enable = 1'b1;
    tick(3);

    // single pulse, latency t+N+2
    qa.push_back({32'd0, 32'd5});
    pulseA(5, 0);
    chk("lat_n0", {63'd0, ifA.record_valid}, 64'd0);
    tick(1);
    chk("lat_n1", {63'd0, ifA.record_valid}, 64'd0);
    tick(1);
    chk("lat_n2", {63'd0, ifA.record_valid}, 64'd1);
    chk("single_pulses", {32'd0, pcA}, 64'd1);
    tick(3);
    chk("single_level", {59'd0, lvA}, 64'd0);

    // two pulses, start-to-start interval 12
    do_reset();
    qa.push_back({32'd0, 32'd5});
    qa.push_back({32'd12, 32'd3});
    pulseA(5, 7);
    pulseA(3, 10);
    chk("two_pulses", {32'd0, pcA}, 64'd2);
    chk("two_level", {59'd0, lvA}, 64'd0);

    // overflow with consumer stalled
    do_reset();
    ifA.record_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if (i < 16)
        qa.push_back({(i == 0) ? 32'd0 : 32'(i + 3), 32'(i + 1)});
      pulseA(i + 1, 3);
    end
    chk("ovf_level", {59'd0, lvA}, 64'd16);
    chk("ovf_count", {48'd0, ovA}, 64'd1);
    chk("ovf_pulses", {32'd0, pcA}, 64'd17);
    ifA.record_ready = 1'b1;
    tick(20);
    chk("ovf_drain_level", {59'd0, lvA}, 64'd0);
    chk("ovf_drain_q", 64'(qa.size()), 64'd0);

    // push at full with a pop in the same cycle
    do_reset();
    ifA.record_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      qa.push_back({(i == 0) ? 32'd0 : 32'd4, 32'd2});
      pulseA(2, 2);
    end
    chk("full_pre_level", {59'd0, lvA}, 64'd16);
    qa.push_back({32'd4, 32'd6});
    pulseA(6, 0);
    tick(1);
    ifA.record_ready = 1'b1;
    tick(1);
    ifA.record_ready = 1'b0;
    chk("full_level", {59'd0, lvA}, 64'd16);
    chk("full_ovf", {48'd0, ovA}, 64'd0);
    chk("full_pulses", {32'd0, pcA}, 64'd17);
    ifA.record_ready = 1'b1;
    tick(20);
    chk("full_drain_level", {59'd0, lvA}, 64'd0);

    // enable drop mid-pulse, then fresh reference
    do_reset();
    qa.push_back({32'd0, 32'd3});
    pulseA(3, 4);
    qa.push_back({32'd7, 32'd4});
    fb = act;
    tick(4);
    enable = 1'b0;
    tick(3);
    fb = ~act;
    enable = 1'b1;
    tick(5);
    qa.push_back({32'd0, 32'd2});
    pulseA(2, 5);
    chk("en_pulses", {32'd0, pcA}, 64'd3);
    chk("en_level", {59'd0, lvA}, 64'd0);

    // reset mid-pulse with records stored
    do_reset();
    ifA.record_ready = 1'b0;
    repeat (3) pulseA(2, 2);
    chk("mid_pre_level", {59'd0, lvA}, 64'd3);
    fb = act;
    tick(2);
    reset = 1'b1;
    fb = ~act;
    tick(1);
    chk("mid_valid", {63'd0, ifA.record_valid}, 64'd0);
    chk("mid_data", ifA.record_data, 64'd0);
    chk("mid_pulses", {32'd0, pcA}, 64'd0);
    chk("mid_ovf", {48'd0, ovA}, 64'd0);
    chk("mid_level", {59'd0, lvA}, 64'd0);
    reset = 1'b0;
    ifA.record_ready = 1'b1;
    tick(8);
    chk("mid_after_level", {59'd0, lvA}, 64'd0);

    // 4-bit counters saturate on a long pulse
    qb.push_back(8'h0F);
    fbB = act;
    tick(20);
    fbB = 16'h0000;
    tick(6);
    chk("sat_pulses", {60'd0, pcB}, 64'd1);
    chk("sat_level", {59'd0, lvB}, 64'd0);

    chk("end_qa", 64'(qa.size()), 64'd0);
    chk("end_qb", 64'(qb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/feedback_pulse_monitor.md
Name: feedback_pulse_monitor

Overview:
- Observes the output of the timed binary feedback controller and reports every completed active pulse to the host/readout side.
- Pulse = consecutive cycles where the monitored feedback value equals the configured active value.
- Per pulse, records width (cycles) and interval since the previous pulse start into a show-ahead FIFO drained by a valid/ready handshake.
- Also exposes running pulse and dropped-record counters.

Parameters:
- valueBitSize, 16, width of monitored feedback value and active value.
- counterBitSize, 32, width of width/interval/pulse counters; all saturate at all-ones.
- fifoDepth, 16, record FIFO depth; power of 2, ≥2.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- enable  in  1  monitoring enable.
- feedbackValue  in  valueBitSize  monitored feedback output.
- activeValue  in  valueBitSize  value that marks the active state.
- record_data  out  2*counterBitSize  {interval, width}; interval in the upper half.
- record_valid  out  1  FIFO not empty.
- record_ready  in  1  consumer accepts head record.
- pulseCount  out  counterBitSize  completed pulses since reset, saturating.
- overflowCount  out  16  records dropped on full FIFO, saturating.
- fifoLevel  out  $clog2(fifoDepth+1)  records currently stored.

Behaviour:
- Reset: every output 0, FIFO empty, state s_noRef, all internal counters and registers 0.
- act_r <= enable && (feedbackValue == activeValue), registered once; act_prev <= act_r. All detection uses act_r/act_prev.
- Rising edge: act_r && !act_prev. Falling edge: !act_r && act_prev.
- s_noRef (no previous pulse start):
  - On rising edge: widthCnt <= 1, intervalCnt <= 1, firstPulse <= 1, go to s_high.
- s_high:
  - While act_r: widthCnt += 1 and intervalCnt += 1, both saturating.
  - On falling edge: push {firstPulse ? 0 : savedInterval, widthCnt}; pulseCount += 1 (saturating); go to s_low; intervalCnt keeps counting.
- s_low:
  - intervalCnt += 1 (saturating).
  - On rising edge: savedInterval <= intervalCnt, intervalCnt <= 1, widthCnt <= 1, firstPulse <= 0, go to s_high.
- Interval definition: cycles from one pulse start to the next (start-to-start).
- Latency: input matching for N consecutive cycles starting at cycle t gives width = N; the record is visible (record_valid=1, empty FIFO) at cycle t+N+2.
- FIFO is show-ahead:
  - record_data = head whenever record_valid.
  - Pop when record_valid && record_ready.
  - Push when full and not popping in the same cycle: record dropped, overflowCount += 1 (saturating); pulseCount still increments.
  - Push and pop in the same cycle: both performed, level unchanged; this applies at full (record accepted) and at empty+push (no pop, since record_valid was 0).
  - Pointer wrap at fifoDepth; fifoLevel is exact, 0..fifoDepth.
- enable low:
  - act_r forces 0. A pulse in progress is closed normally on the resulting falling edge and its width counts only enabled cycles.
  - While enable is low: go to s_noRef, clear firstPulse semantics, so the next pulse reports interval 0.
  - FIFO draining continues regardless of enable.
- Width of an unterminated pulse is never reported.
- Saturated widthCnt/intervalCnt are reported as all-ones.
- Reset asserted mid-pulse or mid-handshake: FIFO and all records are discarded; the next record_valid occurs only after a complete new pulse.
- Default/illegal state: go to s_noRef.

Test Plan:
- Single pulse: activeValue=16'h1234, feedbackValue=16'h1234 for 5 cycles starting at cycle 10, record_ready=1 → record_valid only at cycle 17, record_data={0,5}, pulseCount=1.
- Two pulses: starts at cycles 10 and 22 (widths 5 and 3) → second record {12,3}, pulseCount=2, fifoLevel returns to 0.
- Overflow: record_ready=0, 17 pulses → fifoLevel=16, overflowCount=1, pulseCount=17. Then ready=1 → 16 records popped in order, first one {0,w}.
- Full + simultaneous: FIFO full, record_ready=1 in the same cycle a falling edge pushes → overflowCount unchanged, fifoLevel stays 16, new record appears last.
- Enable drop: enable falls after 4 active cycles of a pulse → record {x,4}. Next pulse after re-enable → interval field 0.
- Reset mid-pulse with 3 records stored → all outputs 0 next cycle. counterBitSize=4 override with 20-cycle pulse → width 4'hF.
